// File: rtl/data_router_pkg.sv
// Shared definitions for the data router / data combiner pair: config word layout,
// beat counter width, FSM state encoding and the per-stream beat count helper.
package data_router_pkg;

  localparam int CNT_W   = 14;
  localparam int FIELD_W = 5;

  typedef struct packed {
    logic [FIELD_W-1:0] symbol_1;
    logic [FIELD_W-1:0] prb_1;
    logic [FIELD_W-1:0] symbol_2;
    logic [FIELD_W-1:0] prb_2;
    logic [FIELD_W-1:0] symbol_3;
    logic [FIELD_W-1:0] prb_3;
  } config_param;

  localparam int CONFIG_BIT_WIDTH = $bits(config_param);

  typedef enum logic [2:0] {
    IDLE,
    CONFIG_READ,
    CONFIG_CALC,
    MERGE_1,
    MERGE_2,
    MERGE_3,
    DRAIN
  } combiner_state_t;

  // 31*31*12 = 11532 fits in 14 bits, so the product never truncates.
  function automatic logic [CNT_W-1:0] calc_beats(input logic [FIELD_W-1:0] symbol,
                                                 input logic [FIELD_W-1:0] prb);
    return CNT_W'(symbol) * CNT_W'(prb) * CNT_W'(12);
  endfunction

endpackage

// File: rtl/data_combiner_if.sv
// Handshake bundle of the data combiner: config stream, three input streams, merged output.
// The master modport is the combiner side, slave is its environment.
interface data_combiner_if #(parameter int DATA_WIDTH = 64);
  import data_router_pkg::*;

  logic [CONFIG_BIT_WIDTH-1:0] s_axi_config_data;
  logic                        s_axi_config_valid;
  logic                        s_axi_config_ready;

  logic [DATA_WIDTH-1:0]       in_axi_data_1;
  logic                        in_axi_valid_1;
  logic                        in_axi_ready_1;
  logic [DATA_WIDTH-1:0]       in_axi_data_2;
  logic                        in_axi_valid_2;
  logic                        in_axi_ready_2;
  logic [DATA_WIDTH-1:0]       in_axi_data_3;
  logic                        in_axi_valid_3;
  logic                        in_axi_ready_3;

  logic [DATA_WIDTH-1:0]       m_axi_data;
  logic                        m_axi_valid;
  logic                        m_axi_ready;
  logic [1:0]                  m_axi_id;
  logic                        m_axi_last;

  modport master (
    input  s_axi_config_data, s_axi_config_valid,
    output s_axi_config_ready,
    input  in_axi_data_1, in_axi_valid_1,
    output in_axi_ready_1,
    input  in_axi_data_2, in_axi_valid_2,
    output in_axi_ready_2,
    input  in_axi_data_3, in_axi_valid_3,
    output in_axi_ready_3,
    output m_axi_data, m_axi_valid, m_axi_id, m_axi_last,
    input  m_axi_ready
  );

  modport slave (
    output s_axi_config_data, s_axi_config_valid,
    input  s_axi_config_ready,
    output in_axi_data_1, in_axi_valid_1,
    input  in_axi_ready_1,
    output in_axi_data_2, in_axi_valid_2,
    input  in_axi_ready_2,
    output in_axi_data_3, in_axi_valid_3,
    input  in_axi_ready_3,
    input  m_axi_data, m_axi_valid, m_axi_id, m_axi_last,
    output m_axi_ready
  );

endinterface

// File: rtl/data_combiner_out_slice.sv
// Single-entry output register slice for the combiner: holds data/id/last with valid
// until the downstream ready, and reloads in the same cycle for full throughput.
module data_combiner_out_slice #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_id,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_id,
  output logic                  out_last
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 2'd0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_id    <= in_id;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_combiner.sv
// Merges three AXI-stream inputs into one output in fixed order 1->2->3, sized per frame
// by a config word. Optional DATA_COMBINER_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module data_combiner
  import data_router_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  data_combiner_if.master       bus,
  output logic                  busy
`ifdef DATA_COMBINER_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_count
`endif
);

  combiner_state_t       state;
  config_param           cfg;
  logic [CNT_W-1:0]      cnt_1, cnt_2, cnt_3;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  cfg_ready;
  logic [CNT_W-1:0]      calc_1, calc_2, calc_3;

  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [1:0]            cur_id;
  logic [CNT_W-1:0]      cur_cnt;
  logic                  cur_final;
  logic                  slice_in_ready;
  logic                  accept;
  logic                  last_beat;

  assign calc_1 = calc_beats(cfg.symbol_1, cfg.prb_1);
  assign calc_2 = calc_beats(cfg.symbol_2, cfg.prb_2);
  assign calc_3 = calc_beats(cfg.symbol_3, cfg.prb_3);

  // First stream after stream k with a non-zero beat count; k=0 means start of frame.
  function automatic combiner_state_t next_after(input logic [1:0]       k,
                                                 input logic [CNT_W-1:0] c1,
                                                 input logic [CNT_W-1:0] c2,
                                                 input logic [CNT_W-1:0] c3);
    combiner_state_t nxt;
    nxt = DRAIN;
    if (k < 2'd3 && c3 != '0) nxt = MERGE_3;
    if (k < 2'd2 && c2 != '0) nxt = MERGE_2;
    if (k < 2'd1 && c1 != '0) nxt = MERGE_1;
    return nxt;
  endfunction

  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    cur_id    = 2'd0;
    cur_cnt   = '0;
    cur_final = 1'b0;
    case (state)
      MERGE_1: begin
        cur_valid = bus.in_axi_valid_1;
        cur_data  = bus.in_axi_data_1;
        cur_id    = 2'd1;
        cur_cnt   = cnt_1;
        cur_final = (cnt_2 == '0) && (cnt_3 == '0);
      end
      MERGE_2: begin
        cur_valid = bus.in_axi_valid_2;
        cur_data  = bus.in_axi_data_2;
        cur_id    = 2'd2;
        cur_cnt   = cnt_2;
        cur_final = (cnt_3 == '0);
      end
      MERGE_3: begin
        cur_valid = bus.in_axi_valid_3;
        cur_data  = bus.in_axi_data_3;
        cur_id    = 2'd3;
        cur_cnt   = cnt_3;
        cur_final = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept    = cur_valid && slice_in_ready;
  assign last_beat = (beat_cnt == cur_cnt - CNT_W'(1));

  // Readies depend only on state and slice occupancy, never on the input valids.
  assign bus.in_axi_ready_1     = (state == MERGE_1) && slice_in_ready;
  assign bus.in_axi_ready_2     = (state == MERGE_2) && slice_in_ready;
  assign bus.in_axi_ready_3     = (state == MERGE_3) && slice_in_ready;
  assign bus.s_axi_config_ready = cfg_ready;
  assign busy                   = !cfg_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cfg       <= '0;
      cnt_1     <= '0;
      cnt_2     <= '0;
      cnt_3     <= '0;
      beat_cnt  <= '0;
      cfg_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= CONFIG_READ;
          cfg_ready <= 1'b1;
        end
        CONFIG_READ: begin
          if (bus.s_axi_config_valid) begin
            cfg       <= bus.s_axi_config_data;
            cfg_ready <= 1'b0;
            state     <= CONFIG_CALC;
          end
        end
        CONFIG_CALC: begin
          cnt_1    <= calc_1;
          cnt_2    <= calc_2;
          cnt_3    <= calc_3;
          beat_cnt <= '0;
          // An all-zero frame produces no beats, so skip DRAIN entirely.
          if (next_after(2'd0, calc_1, calc_2, calc_3) == DRAIN) begin
            state     <= CONFIG_READ;
            cfg_ready <= 1'b1;
          end else begin
            state <= next_after(2'd0, calc_1, calc_2, calc_3);
          end
        end
        MERGE_1, MERGE_2, MERGE_3: begin
          if (accept) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= next_after(cur_id, cnt_1, cnt_2, cnt_3);
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!bus.m_axi_valid) begin
            state     <= CONFIG_READ;
            cfg_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  data_combiner_out_slice #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_slice (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_ready  (slice_in_ready),
    .in_data   (cur_data),
    .in_id     (cur_id),
    .in_last   (last_beat && cur_final),
    .out_valid (bus.m_axi_valid),
    .out_ready (bus.m_axi_ready),
    .out_data  (bus.m_axi_data),
    .out_id    (bus.m_axi_id),
    .out_last  (bus.m_axi_last)
  );

`ifdef DATA_COMBINER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (bus.m_axi_valid && bus.m_axi_ready && bus.m_axi_last) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_combiner.sv
// Scoreboard bench for data_combiner: expected beats are queued when a config is issued and
// popped as the merged stream emits them. Frame counter checks need DATA_COMBINER_FRAME_CNT_EN.
module tb_data_combiner;
  import data_router_pkg::*;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  logic busy;
`ifdef DATA_COMBINER_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  data_combiner_if #(.DATA_WIDTH(DW)) bus ();

  data_combiner #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy)
`ifdef DATA_COMBINER_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;
  int    pops   = 0;
  int    seq[3];
  int    pushed[3];
  logic  vld[3];
  logic  toggle_ready = 1'b0;
  logic  rand_valid   = 1'b0;

  function automatic logic [DW-1:0] make_data(input int k, input int n);
    return {8'(k), 24'h5A5A5A, 32'(n)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveSources();
    bus.in_axi_valid_1 = vld[0];
    bus.in_axi_valid_2 = vld[1];
    bus.in_axi_valid_3 = vld[2];
    bus.in_axi_data_1  = make_data(1, seq[0]);
    bus.in_axi_data_2  = make_data(2, seq[1]);
    bus.in_axi_data_3  = make_data(3, seq[2]);
  endtask

  // One clock: compare the output beat at the falling edge, then advance sources after the rising edge.
  task automatic tick();
    logic [2:0] hs;
    logic       hs_cfg;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checkOutput("idle_valid", 64'(bus.m_axi_valid), 64'(0));
    end else if (bus.m_axi_valid) begin
      checkOutput("beat_data", bus.m_axi_data, exp_q[0].data);
      checkOutput("beat_id", 64'(bus.m_axi_id), 64'(exp_q[0].id));
      checkOutput("beat_last", 64'(bus.m_axi_last), 64'(exp_q[0].last));
      if (bus.m_axi_ready && !reset) begin
        void'(exp_q.pop_front());
        pops++;
      end
    end
    if (bus.m_axi_valid && !bus.m_axi_ready)
      checkOutput("stall_in_ready",
                  64'({bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1}), 64'(0));
    hs = {bus.in_axi_valid_3 && bus.in_axi_ready_3,
          bus.in_axi_valid_2 && bus.in_axi_ready_2,
          bus.in_axi_valid_1 && bus.in_axi_ready_1} & {3{!reset}};
    hs_cfg = bus.s_axi_config_valid && bus.s_axi_config_ready && !reset;
    @(posedge clk);
    #1;
    cycle++;
    for (int k = 0; k < 3; k++) begin
      if (hs[k]) seq[k]++;
      if (hs[k] || !vld[k]) vld[k] = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    driveSources();
    if (hs_cfg) bus.s_axi_config_valid = 1'b0;
    bus.m_axi_ready = toggle_ready ? !bus.m_axi_ready : 1'b1;
  endtask

  task automatic applyStimulus(input int s1, input int p1, input int s2, input int p2,
                               input int s3, input int p3);
    config_param cfg;
    int cnt[3];
    int last_k;
    int n;
    cfg.symbol_1 = 5'(s1);
    cfg.prb_1    = 5'(p1);
    cfg.symbol_2 = 5'(s2);
    cfg.prb_2    = 5'(p2);
    cfg.symbol_3 = 5'(s3);
    cfg.prb_3    = 5'(p3);
    cnt[0] = s1 * p1 * 12;
    cnt[1] = s2 * p2 * 12;
    cnt[2] = s3 * p3 * 12;
    last_k = -1;
    for (int k = 0; k < 3; k++) if (cnt[k] != 0) last_k = k;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < cnt[k]; i++)
        exp_q.push_back('{data: make_data(k + 1, pushed[k] + i), id: 2'(k + 1),
                          last: 1'((k == last_k) && (i == cnt[k] - 1))});
      pushed[k] += cnt[k];
    end
    bus.s_axi_config_data  = cfg;
    bus.s_axi_config_valid = 1'b1;
    n = 0;
    while (bus.s_axi_config_valid && n < 40000) begin
      tick();
      n++;
    end
    checkOutput("cfg_accept", 64'(bus.s_axi_config_valid), 64'(0));
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_queue", 64'(exp_q.size()), 64'(0));
    checkOutput("drain_busy", 64'(busy), 64'(0));
  endtask

  // Asserts reset for one edge, restarts the sources and checks the post-reset state.
  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      seq[k]    = 0;
      pushed[k] = 0;
      vld[k]    = 1'b1;
    end
    driveSources();
    checkOutput("rst_m_valid", 64'(bus.m_axi_valid), 64'(0));
    checkOutput("rst_m_data", bus.m_axi_data, 64'(0));
    checkOutput("rst_m_id", 64'(bus.m_axi_id), 64'(0));
    checkOutput("rst_m_last", 64'(bus.m_axi_last), 64'(0));
    checkOutput("rst_cfg_ready", 64'(bus.s_axi_config_ready), 64'(0));
    checkOutput("rst_in_ready",
                64'({bus.in_axi_ready_3, bus.in_axi_ready_2, bus.in_axi_ready_1}), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(1));
`ifdef DATA_COMBINER_FRAME_CNT_EN
    checkOutput("rst_frame_count", 64'(frame_count), 64'(0));
`endif
    reset = 1'b0;
    tick();
    checkOutput("cfg_ready_after_idle", 64'(bus.s_axi_config_ready), 64'(1));
  endtask

  initial begin
    int base;
    int first;
    int last;
    int n;
    reset                  = 1'b1;
    bus.s_axi_config_data  = '0;
    bus.s_axi_config_valid = 1'b0;
    bus.m_axi_ready        = 1'b1;
    for (int k = 0; k < 3; k++) begin
      seq[k]    = 0;
      pushed[k] = 0;
      vld[k]    = 1'b1;
    end
    driveSources();
    repeat (2) @(posedge clk);
    doReset();

    $display("[TB] frame (1,1)x3 at full rate");
    applyStimulus(1, 1, 1, 1, 1, 1);
    base  = pops;
    first = -1;
    last  = -1;
    n     = 0;
    while (pops - base < 36 && n < 500) begin
      tick();
      if (first < 0 && pops > base) first = cycle;
      n++;
    end
    last = cycle;
    checkOutput("full_rate_beats", 64'(pops - base), 64'(36));
    checkOutput("full_rate_span", 64'(last - first), 64'(35));
    waitDrain(100);

    $display("[TB] frame (2,3),(0,5),(1,1) skips stream 2");
    applyStimulus(2, 3, 0, 5, 1, 1);
    base = pops;
    waitDrain(1000);
    checkOutput("skip_beats", 64'(pops - base), 64'(84));

    $display("[TB] all-zero frame");
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("zero_cfg_ready_calc", 64'(bus.s_axi_config_ready), 64'(0));
    tick();
    checkOutput("zero_cfg_ready_back", 64'(bus.s_axi_config_ready), 64'(1));
    checkOutput("zero_busy", 64'(busy), 64'(0));
    repeat (3) tick();

    $display("[TB] frame (1,1)x3 with toggling ready and gappy sources");
    toggle_ready = 1'b1;
    rand_valid   = 1'b1;
    base = pops;
    applyStimulus(1, 1, 1, 1, 1, 1);
    waitDrain(2000);
    checkOutput("stall_beats", 64'(pops - base), 64'(36));
    toggle_ready    = 1'b0;
    rand_valid      = 1'b0;
    bus.m_axi_ready = 1'b1;
    tick();

    $display("[TB] reset in the middle of stream 1");
    applyStimulus(1, 1, 1, 1, 1, 1);
    base = pops;
    n    = 0;
    while (pops - base < 5 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("mid_reset_progress", 64'(pops - base), 64'(5));
    doReset();
    base = pops;
    applyStimulus(1, 1, 1, 1, 1, 1);
    waitDrain(200);
    checkOutput("after_reset_beats", 64'(pops - base), 64'(36));

    $display("[TB] three back-to-back frames then maximum frame");
    doReset();
    applyStimulus(1, 1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1, 1, 1);
    waitDrain(500);
`ifdef DATA_COMBINER_FRAME_CNT_EN
    checkOutput("frame_count_3", 64'(frame_count), 64'(3));
`endif
    base = pops;
    applyStimulus(31, 31, 31, 31, 31, 31);
    waitDrain(40000);
    checkOutput("max_frame_beats", 64'(pops - base), 64'(3 * 11532));
`ifdef DATA_COMBINER_FRAME_CNT_EN
    checkOutput("frame_count_4", 64'(frame_count), 64'(4));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
